// File: rtl/ifft_cmult_pipe_pkg.sv
// Shared constants and width helpers for the NB-IoT IFFT complex multiplier pipeline.
package ifft_cmult_pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 10;

  localparam int PROD_W_DEF = 2 * DATA_W_DEF;
  localparam int SUM_W_DEF  = 2 * DATA_W_DEF + 1;

  function automatic int prodWidth(input int dataW);
    return 2 * dataW;
  endfunction

  function automatic int sumWidth(input int dataW);
    return 2 * dataW + 1;
  endfunction

  // Saturation bounds of a dataW-bit two's complement result, returned at 64 bits.
  function automatic longint satMax(input int dataW);
    return (64'sd1 <<< (dataW - 1)) - 64'sd1;
  endfunction

  function automatic longint satMin(input int dataW);
    return -(64'sd1 <<< (dataW - 1));
  endfunction

  localparam longint SAT_MAX_DEF = satMax(DATA_W_DEF);
  localparam longint SAT_MIN_DEF = satMin(DATA_W_DEF);

endpackage

// File: rtl/ifft_round_sat.sv
// Rounds or truncates a full-precision sum, rescales it by FRAC_W and clips to DATA_W.
module ifft_round_sat
  import ifft_cmult_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic signed [2*DATA_W:0]   i_sum,
  input  logic                       i_round_en,
  output logic signed [DATA_W-1:0]  o_data,
  output logic                       o_ovf
);

  localparam int SUM_W = sumWidth(DATA_W);
  localparam logic signed [SUM_W-1:0] HALF    = SUM_W'(1) << (FRAC_W - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(satMax(DATA_W));
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(satMin(DATA_W));

  logic signed [SUM_W-1:0] w_rounded;
  logic signed [SUM_W-1:0] w_shifted;

  // The sum has headroom above the largest product sum, so adding HALF cannot wrap.
  assign w_rounded = i_round_en ? (i_sum + HALF) : i_sum;
  assign w_shifted = w_rounded >>> FRAC_W;

  always_comb begin
    o_ovf  = 1'b0;
    o_data = w_shifted[DATA_W-1:0];
    if (w_shifted > SAT_MAX) begin
      o_data = SAT_MAX[DATA_W-1:0];
      o_ovf  = 1'b1;
    end else if (w_shifted < SAT_MIN) begin
      o_data = SAT_MIN[DATA_W-1:0];
      o_ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/ifft_cmult_pipe.sv
// Three-stage pipelined fixed-point complex multiplier with conjugate, rounding,
// saturation and a valid/ready handshake driven by a single global advance.
module ifft_cmult_pipe
  import ifft_cmult_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic signed [DATA_W-1:0]  i_op_1_real,
  input  logic signed [DATA_W-1:0]  i_op_1_imag,
  input  logic signed [DATA_W-1:0]  i_op_2_real,
  input  logic signed [DATA_W-1:0]  i_op_2_imag,
  input  logic                      i_conj_en,
  input  logic                      i_round_en,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic signed [DATA_W-1:0]  o_result_real,
  output logic signed [DATA_W-1:0]  o_result_imag,
  output logic                      o_ovf,
  output logic                      o_ovf_sticky,
  input  logic                      i_ovf_clr
);

  localparam int PROD_W = prodWidth(DATA_W);
  localparam int SUM_W  = sumWidth(DATA_W);

  logic                      w_adv;

  logic                      r_s1Valid, r_s1Conj, r_s1Round;
  logic signed [DATA_W-1:0]  r_s1Ar, r_s1Ai, r_s1Br, r_s1Bi;

  logic                      r_s2Valid, r_s2Conj, r_s2Round;
  logic signed [PROD_W-1:0]  r_s2Rr, r_s2Ii, r_s2Ir, r_s2Ri;

  logic signed [SUM_W-1:0]   w_sumRe, w_sumIm;
  logic signed [DATA_W-1:0]  w_satRe, w_satIm;
  logic                      w_ovfRe, w_ovfIm;

  logic                      r_s3Valid, r_s3Ovf, r_sticky;
  logic signed [DATA_W-1:0]  r_s3Re, r_s3Im;

  assign w_adv      = !r_s3Valid || i_out_ready;
  assign o_in_ready = w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Conj  <= 1'b0;
      r_s1Round <= 1'b0;
      r_s1Ar    <= '0;
      r_s1Ai    <= '0;
      r_s1Br    <= '0;
      r_s1Bi    <= '0;
    end else if (w_adv) begin
      r_s1Valid <= i_in_valid;
      r_s1Conj  <= i_conj_en;
      r_s1Round <= i_round_en;
      r_s1Ar    <= i_op_1_real;
      r_s1Ai    <= i_op_1_imag;
      r_s1Br    <= i_op_2_real;
      r_s1Bi    <= i_op_2_imag;
    end
  end

  // Products are kept un-negated; conjugation is applied as a sign swap in the sum stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Conj  <= 1'b0;
      r_s2Round <= 1'b0;
      r_s2Rr    <= '0;
      r_s2Ii    <= '0;
      r_s2Ir    <= '0;
      r_s2Ri    <= '0;
    end else if (w_adv) begin
      r_s2Valid <= r_s1Valid;
      r_s2Conj  <= r_s1Conj;
      r_s2Round <= r_s1Round;
      r_s2Rr    <= PROD_W'(r_s1Ar) * PROD_W'(r_s1Br);
      r_s2Ii    <= PROD_W'(r_s1Ai) * PROD_W'(r_s1Bi);
      r_s2Ir    <= PROD_W'(r_s1Ai) * PROD_W'(r_s1Br);
      r_s2Ri    <= PROD_W'(r_s1Ar) * PROD_W'(r_s1Bi);
    end
  end

  assign w_sumRe = r_s2Conj ? (SUM_W'(r_s2Rr) + SUM_W'(r_s2Ii)) : (SUM_W'(r_s2Rr) - SUM_W'(r_s2Ii));
  assign w_sumIm = r_s2Conj ? (SUM_W'(r_s2Ir) - SUM_W'(r_s2Ri)) : (SUM_W'(r_s2Ir) + SUM_W'(r_s2Ri));

  ifft_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_rsRe (
    .i_sum      (w_sumRe),
    .i_round_en (r_s2Round),
    .o_data     (w_satRe),
    .o_ovf      (w_ovfRe)
  );

  ifft_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_rsIm (
    .i_sum      (w_sumIm),
    .i_round_en (r_s2Round),
    .o_data     (w_satIm),
    .o_ovf      (w_ovfIm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3Valid <= 1'b0;
      r_s3Ovf   <= 1'b0;
      r_s3Re    <= '0;
      r_s3Im    <= '0;
    end else if (w_adv) begin
      r_s3Valid <= r_s2Valid;
      r_s3Ovf   <= w_ovfRe || w_ovfIm;
      r_s3Re    <= w_satRe;
      r_s3Im    <= w_satIm;
    end
  end

  // A saturating transfer takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (r_s3Valid && i_out_ready && r_s3Ovf) begin
      r_sticky <= 1'b1;
    end else if (i_ovf_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign o_out_valid   = r_s3Valid;
  assign o_result_real = r_s3Re;
  assign o_result_imag = r_s3Im;
  assign o_ovf         = r_s3Ovf;
  assign o_ovf_sticky  = r_sticky;

endmodule

// File: tb/tb_ifft_cmult_pipe.sv
// Directed self-checking bench for ifft_cmult_pipe with the default Q6.10 format.
module tb_ifft_cmult_pipe;

  logic               clk;
  logic               rstN;
  logic               inValid;
  logic               inReady;
  logic signed [15:0] op1Re, op1Im, op2Re, op2Im;
  logic               conjEn;
  logic               roundEn;
  logic               outValid;
  logic               outReady;
  logic signed [15:0] resultReal, resultImag;
  logic               ovf;
  logic               ovfSticky;
  logic               ovfClr;

  int testsRun  = 0;
  int testsFail = 0;

  ifft_cmult_pipe #(.DATA_W(16), .FRAC_W(10)) dut (
    .clk           (clk),
    .rst_n         (rstN),
    .i_in_valid    (inValid),
    .o_in_ready    (inReady),
    .i_op_1_real   (op1Re),
    .i_op_1_imag   (op1Im),
    .i_op_2_real   (op2Re),
    .i_op_2_imag   (op2Im),
    .i_conj_en     (conjEn),
    .i_round_en    (roundEn),
    .o_out_valid   (outValid),
    .i_out_ready   (outReady),
    .o_result_real (resultReal),
    .o_result_imag (resultImag),
    .o_ovf         (ovf),
    .o_ovf_sticky  (ovfSticky),
    .i_ovf_clr     (ovfClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    testsRun++;
    if (observed != expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic driveOperands(input int ar, input int ai, input int br, input int bi,
                               input bit conj, input bit rnd);
    op1Re   = 16'(ar);
    op1Im   = 16'(ai);
    op2Re   = 16'(br);
    op2Im   = 16'(bi);
    conjEn  = conj;
    roundEn = rnd;
  endtask

  // Sends one sample with out_ready held high and checks latency, data and ovf.
  task automatic applyStimulus(input string tag, input int ar, input int ai, input int br,
                               input int bi, input bit conj, input bit rnd,
                               input int expRe, input int expIm, input bit expOvf);
    int cycles;
    @(posedge clk);
    #1;
    driveOperands(ar, ai, br, bi, conj, rnd);
    inValid = 1'b1;
    checkOutput({tag, " in_ready"}, inReady, 1);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      inValid = 1'b0;
      cycles++;
    end while (!outValid && cycles < 10);
    checkOutput({tag, " latency"}, cycles, 3);
    checkOutput({tag, " real"}, resultReal, expRe);
    checkOutput({tag, " imag"}, resultImag, expIm);
    checkOutput({tag, " ovf"}, ovf, expOvf);
  endtask

  int          a1r[8], a1i[8], a2r[8], a2i[8];
  bit          cj[8];
  longint      expRe[8], expIm[8];
  logic [15:0] readyPat;
  int          sent, recv, cyc, seenValid;
  bit          accept;
  longint      fullRe, fullIm;

  initial begin
    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    ovfClr   = 1'b0;
    driveOperands(0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    checkOutput("reset out_valid", outValid, 0);
    checkOutput("reset real", resultReal, 0);
    checkOutput("reset imag", resultImag, 0);
    checkOutput("reset ovf", ovf, 0);
    checkOutput("reset sticky", ovfSticky, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", inReady, 1);
    outReady = 1'b1;

    applyStimulus("identity", 1024, 0, 1024, 0, 1'b0, 1'b0, 1024, 0, 1'b0);
    applyStimulus("j*j", 0, 1024, 0, 1024, 1'b0, 1'b0, -1024, 0, 1'b0);
    applyStimulus("j*conj(j)", 0, 1024, 0, 1024, 1'b1, 1'b0, 1024, 0, 1'b0);
    applyStimulus("pos trunc", 1, 0, 512, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus("pos round", 1, 0, 512, 0, 1'b0, 1'b1, 1, 0, 1'b0);
    applyStimulus("neg trunc", -1, 0, 512, 0, 1'b0, 1'b0, -1, 0, 1'b0);
    applyStimulus("neg round", -1, 0, 512, 0, 1'b0, 1'b1, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("sticky before sat", ovfSticky, 0);

    applyStimulus("sat max", 32767, 32767, 32767, 32767, 1'b0, 1'b0, 0, 32767, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("sticky after sat", ovfSticky, 1);
    applyStimulus("sat min conj", -32768, 0, 0, -32768, 1'b1, 1'b0, 0, -32768, 1'b1);
    ovfClr = 1'b1;
    @(posedge clk);
    #1;
    ovfClr = 1'b0;
    checkOutput("sticky set beats clear", ovfSticky, 1);
    ovfClr = 1'b1;
    @(posedge clk);
    #1;
    ovfClr = 1'b0;
    checkOutput("sticky cleared", ovfSticky, 0);

    // Backpressure: 8 back-to-back samples against a fixed out_ready pattern.
    for (int i = 0; i < 8; i++) begin
      a1r[i] = 100 * i - 300;
      a1i[i] = 50 - 37 * i;
      a2r[i] = 900 + 13 * i;
      a2i[i] = -200 + 90 * i;
      cj[i]  = i[0];
      if (cj[i]) begin
        fullRe = longint'(a1r[i]) * a2r[i] + longint'(a1i[i]) * a2i[i];
        fullIm = longint'(a1i[i]) * a2r[i] - longint'(a1r[i]) * a2i[i];
      end else begin
        fullRe = longint'(a1r[i]) * a2r[i] - longint'(a1i[i]) * a2i[i];
        fullIm = longint'(a1i[i]) * a2r[i] + longint'(a1r[i]) * a2i[i];
      end
      expRe[i] = fullRe >>> 10;
      expIm[i] = fullIm >>> 10;
    end
    readyPat = 16'b0110_1001_1100_1011;
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 8 && cyc < 200) begin
      @(negedge clk);
      outReady = readyPat[cyc % 16];
      if (sent < 8) begin
        driveOperands(a1r[sent], a1i[sent], a2r[sent], a2i[sent], cj[sent], 1'b0);
        inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      #1;
      checkOutput("bp in_ready", inReady, !(outValid && !outReady));
      if (outValid) begin
        checkOutput("bp real", resultReal, expRe[recv]);
        checkOutput("bp imag", resultImag, expIm[recv]);
        if (outReady) recv++;
      end
      accept = inValid && inReady;
      @(posedge clk);
      if (accept) sent++;
      cyc++;
    end
    checkOutput("bp received", recv, 8);
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("bp no extra output", outValid, 0);

    // Reset with three samples in flight.
    @(negedge clk);
    driveOperands(32767, 32767, 32767, 32767, 1'b0, 1'b0);
    inValid = 1'b1;
    @(negedge clk);
    driveOperands(1024, 0, 1024, 0, 1'b0, 1'b0);
    @(negedge clk);
    driveOperands(0, 1024, 0, 1024, 1'b0, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("pre-reset out_valid", outValid, 1);
    checkOutput("pre-reset imag", resultImag, 32767);
    rstN = 1'b0;
    #1;
    checkOutput("async reset out_valid", outValid, 0);
    checkOutput("async reset imag", resultImag, 0);
    checkOutput("async reset ovf", ovf, 0);
    checkOutput("async reset sticky", ovfSticky, 0);
    @(negedge clk);
    rstN = 1'b1;
    seenValid = 0;
    repeat (5) begin
      @(negedge clk);
      if (outValid) seenValid++;
    end
    checkOutput("no stale output", seenValid, 0);
    applyStimulus("after reset", 1024, 0, 1024, 0, 1'b0, 1'b0, 1024, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule

// File: doc/ifft_cmult_pipe.md
Name: ifft_cmult_pipe

Overview:
- Parametrised, pipelined signed fixed-point complex multiplier for the NB-IoT IFFT datapath. Successor to the combinational twiddle multiplier.
- Adds:
  - configurable data width and fraction width;
  - per-sample conjugate mode, which gives FFT/IFFT twiddle reuse;
  - selectable round-half-up or truncation;
  - saturation with overflow reporting;
  - a valid/ready handshake with full backpressure.
- Sits between the twiddle ROM/butterfly operand mux and the butterfly adder stage.

Parameters:
- DATA_W, 16, signed operand and result width (two's complement).
- FRAC_W, 10, fraction bits of the operand/result format (default Q6.10). Legal range 1 to 2*DATA_W-2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- op_1_real  in  DATA_W  signed, operand 1 real part
- op_1_imag  in  DATA_W  signed, operand 1 imaginary part
- op_2_real  in  DATA_W  signed, operand 2 (twiddle) real part
- op_2_imag  in  DATA_W  signed, operand 2 (twiddle) imaginary part
- conj_en  in  1  1: multiply op_1 by conj(op_2); sampled with operands
- round_en  in  1  1: round half up; 0: truncate (floor); sampled with operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result_real  out  DATA_W  signed, real part of result
- result_imag  out  DATA_W  signed, imaginary part of result
- ovf  out  1  this result saturated (real or imag); qualified by out_valid
- ovf_sticky  out  1  a saturation occurred since reset or the last clear
- ovf_clr  in  1  clears ovf_sticky

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valid bits, out_valid, result_real, result_imag, ovf and ovf_sticky are 0. in_ready = 1 one cycle after reset release (combinational from the empty pipeline).
- Reset mid-stream discards all in-flight samples. No output is produced for them after release.
- Pipeline:
  - Three register stages S1, S2, S3. S3 drives the outputs.
  - Global advance: adv = !out_valid | out_ready.
  - in_ready = adv (combinational). Input is accepted when in_valid & in_ready.
  - On adv, every stage loads from its predecessor (S1 loads the input and in_valid & in_ready). Otherwise all stages hold.
  - Latency: an accepted sample appears on out_valid exactly 3 cycles later when unstalled.
  - Throughput: 1 sample/cycle.
  - Bubbles propagate as invalid stages. No combinational path from out_ready to any output data.
- S1: registers the operands, conj_en and round_en.
- S2: four 2*DATA_W signed products. When conj_en = 1, op_2_imag is treated as its negation: the cross terms change sign and the product is computed at full width, so negating -2^(DATA_W-1) cannot overflow.
- S3:
  - re = rr - ii, im = ir + ri, computed at 2*DATA_W+1 bits (with conj: re = rr + ii, im = ir - ri).
  - If round_en, add 2^(FRAC_W-1).
  - Arithmetic shift right by FRAC_W.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - ovf = 1 if either part clipped.
- With round_en = 0 and no overflow, the result is bit-identical to bits [FRAC_W+DATA_W-1:FRAC_W] of the full product.
- ovf_sticky:
  - Set when a result with ovf = 1 is transferred (out_valid & out_ready).
  - Cleared by ovf_clr.
  - If a set and a clear occur in the same cycle, the set wins.
- Output data is stable while out_valid = 1 and out_ready = 0.

Decomposition:
- Shared package holds:
  - the default DATA_W/FRAC_W constants;
  - the product width and sum width (2*DATA_W, 2*DATA_W+1) localparams;
  - the saturation bounds.
- One natural sub-module, ifft_round_sat: sum width in, DATA_W out plus an overflow bit. It is combinational and instantiated twice (real and imaginary).

Test Plan:
- Identity: (1024,0)*(1024,0), round_en=0 -> (1024,0), ovf=0; out_valid 3 cycles after acceptance.
- Conjugate: (0,1024)*(0,1024) with conj_en=0 -> (-1024,0); same operands with conj_en=1 -> (1024,0).
- Rounding:
  - (1,0)*(512,0) -> 0 truncated, 1 rounded.
  - (-1,0)*(512,0) -> -1 truncated, 0 rounded.
- Saturation: (32767,32767)*(32767,32767) -> real 0, imag 32767, ovf=1, ovf_sticky=1. Pulsing ovf_clr together with another overflow result keeps ovf_sticky=1.
- Backpressure: stream 8 back-to-back samples with out_ready toggling pseudo-randomly -> all 8 results in order, none lost or duplicated, data stable while stalled, in_ready low only when S3 is valid and out_ready=0.
- Reset mid-stream: assert rst_n low with 3 samples in flight -> outputs 0 immediately (asynchronous); no stale out_valid after release; next sample has normal 3-cycle latency.
